ghpc_d1_operand_feeder: RTL and testbench

Upstream sequencing stage for the first-order (d=1) GHPC AND-chain gadget pair (two cascaded 2-share GHPC AND gadgets: t = a·b, d = t·c). It accepts 2-share operands over a valid/ready handshake and draws 2 fresh random bits per operation from an internal reseedable LFSR. It drives the gadget inputs from registers, holds them stable for the gadget's full evaluation window, then captures the 2-share result and returns it over a valid/ready handshake. It never recombines shares.

---
 rtl/ghpc_pkg.sv | 17 +
 rtl/ghpc_lfsr.sv | 38 +++
 rtl/ghpc_d1_operand_feeder.sv | 140 ++++++++++++++
 tb/tb_ghpc_d1_operand_feeder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghpc_pkg.sv
// Shared types and constants for the d=1 GHPC AND-chain operand feeder.
package ghpc_pkg;

  typedef logic [1:0] share2_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    CAPTURE,
    DONE
  } feeder_state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

endpackage

// File: rtl/ghpc_lfsr.sv
// Reseedable right-shifting Galois LFSR; a load takes priority over a step.
module ghpc_lfsr #(
  parameter int unsigned        W            = 32,
  parameter logic [W-1:0]       POLY         = ghpc_pkg::LFSR_POLY,
  parameter logic [W-1:0]       DEFAULT_SEED = ghpc_pkg::DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // An all-zero state would lock the register, so a zero seed loads the default.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      state_d = {1'b0, state_q[W-1:1]} ^ (state_q[0] ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ghpc_d1_operand_feeder.sv
// Sequences 2-share operands and fresh randomness into the GHPC AND-chain pair,
// holds the gadget inputs for the evaluation window and returns the 2-share result.
module ghpc_d1_operand_feeder #(
  parameter int unsigned        PRNG_W       = 32,
  parameter int unsigned        LATENCY      = 3,
  parameter logic [PRNG_W-1:0]  DEFAULT_SEED = ghpc_pkg::DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  ghpc_pkg::share2_t   in_a,
  input  ghpc_pkg::share2_t   in_b,
  input  ghpc_pkg::share2_t   in_c,
  input  logic                seed_valid,
  input  logic [PRNG_W-1:0]   seed,
  output ghpc_pkg::share2_t   g_a,
  output ghpc_pkg::share2_t   g_b,
  output ghpc_pkg::share2_t   g_c,
  output ghpc_pkg::share2_t   g_r,
  input  ghpc_pkg::share2_t   g_d,
  output logic                out_valid,
  input  logic                out_ready,
  output ghpc_pkg::share2_t   out_d,
  output logic                busy
);

  import ghpc_pkg::*;

  localparam int unsigned         CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(LATENCY - 1);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  share2_t           ga_q, ga_d;
  share2_t           gb_q, gb_d;
  share2_t           gc_q, gc_d;
  share2_t           gr_q, gr_d;
  share2_t           res_q, res_d;

  logic              lfsr_load;
  logic [PRNG_W-1:0] lfsr_state;
  logic              lfsr_unused;

  ghpc_lfsr #(
    .W            (PRNG_W),
    .POLY         (PRNG_W'(LFSR_POLY)),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (1'b1),
    .load  (lfsr_load),
    .seed  (seed),
    .state (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[PRNG_W-1:2];

  // A seed load in IDLE takes the cycle: the LFSR reloads and no operand is taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ga_d      = ga_q;
    gb_d      = gb_q;
    gc_d      = gc_q;
    gr_d      = gr_q;
    res_d     = res_q;
    lfsr_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          lfsr_load = 1'b1;
        end else if (in_valid) begin
          ga_d    = in_a;
          gb_d    = in_b;
          gc_d    = in_c;
          gr_d    = lfsr_state[1:0];
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        res_d   = g_d;
        ga_d    = '0;
        gb_d    = '0;
        gc_d    = '0;
        gr_d    = '0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ga_q    <= '0;
      gb_q    <= '0;
      gc_q    <= '0;
      gr_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      gc_q    <= gc_d;
      gr_q    <= gr_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !seed_valid;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_d     = res_q;
  assign g_a       = ga_q;
  assign g_b       = gb_q;
  assign g_c       = gc_q;
  assign g_r       = gr_q;

endmodule

// File: tb/tb_ghpc_d1_operand_feeder.sv
// Randomized bench for the operand feeder against an operation-level reference model
// and a behavioural gadget-pair model that produces g_d LATENCY edges after its inputs.
module tb_ghpc_d1_operand_feeder;

  localparam int unsigned LAT      = 3;
  localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_a, in_b, in_c;
  logic        seed_valid;
  logic [31:0] seed;
  logic [1:0]  g_a, g_b, g_c, g_r, g_d;
  logic        out_valid, out_ready, busy;
  logic [1:0]  out_d;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ghpc_d1_operand_feeder #(
    .PRNG_W       (32),
    .LATENCY      (LAT),
    .DEFAULT_SEED (DEF_SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .seed_valid (seed_valid),
    .seed       (seed),
    .g_a        (g_a),
    .g_b        (g_b),
    .g_c        (g_c),
    .g_r        (g_r),
    .g_d        (g_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Gadget pair: d recombines to a*b*c, remasked with r[0], three register stages deep.
  function automatic logic [1:0] gadget(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c, input logic [1:0] r);
    logic v;
    v = (a[0] ^ a[1]) & (b[0] ^ b[1]) & (c[0] ^ c[1]);
    return {r[0], v ^ r[0]};
  endfunction

  logic [1:0] p0, p1, p2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= 2'b00; p1 <= 2'b00; p2 <= 2'b00;
    end else begin
      p0 <= gadget(g_a, g_b, g_c, g_r);
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign g_d = p2;

  // Operation-level reference model.
  bit         m_idle, m_outv, m_v, m_outv_seen;
  int         m_age;
  logic [31:0] m_lfsr;
  logic [1:0] m_ga, m_gb, m_gc, m_gr, m_outd;
  bit         track_rate;
  int         last_res, n_res;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic bit rec(input logic [1:0] x);
    return x[0] ^ x[1];
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_outv = 1'b0; m_age = 0; m_lfsr = DEF_SEED;
    m_ga = '0; m_gb = '0; m_gc = '0; m_gr = '0; m_outd = '0; m_v = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_idle) begin
      if (seed_valid) begin
        m_lfsr = (seed == 32'h0) ? DEF_SEED : seed;
      end else begin
        if (in_valid) begin
          m_ga = in_a; m_gb = in_b; m_gc = in_c; m_gr = m_lfsr[1:0];
          m_v = rec(in_a) & rec(in_b) & rec(in_c);
          m_idle = 1'b0; m_age = 0;
        end
        m_lfsr = lfsr_adv(m_lfsr);
      end
    end else begin
      m_lfsr = lfsr_adv(m_lfsr);
      if (m_outv) begin
        if (out_ready) begin
          m_outv = 1'b0; m_idle = 1'b1;
        end
      end else begin
        m_age++;
        if (m_age == LAT + 1) begin
          m_outd = {m_gr[0], m_v ^ m_gr[0]};
          m_outv = 1'b1;
          m_ga = '0; m_gb = '0; m_gc = '0; m_gr = '0;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check_val("in_ready",  32'(in_ready),  32'(m_idle && !seed_valid));
    check_val("busy",      32'(busy),      32'(!m_idle));
    check_val("out_valid", 32'(out_valid), 32'(m_outv));
    check_val("out_d",     32'(out_d),     32'(m_outd));
    check_val("g_a",       32'(g_a),       32'(m_ga));
    check_val("g_b",       32'(g_b),       32'(m_gb));
    check_val("g_c",       32'(g_c),       32'(m_gc));
    check_val("g_r",       32'(g_r),       32'(m_gr));
    if (m_outv && !m_outv_seen) begin
      check_val("recombine", 32'(out_d[0] ^ out_d[1]), 32'(m_v));
      if (track_rate && last_res >= 0) check_val("interval", 32'(cyc - last_res), 32'(LAT + 3));
      last_res = cyc;
      n_res++;
    end
    m_outv_seen = m_outv;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic drive_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    seed_valid = 1'b0; seed = '0; out_ready = 1'b1;
    track_rate = 1'b0; last_res = -1; n_res = 0; m_outv_seen = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset mid-HOLD drops the operation immediately.
    drive_op(2'b01, 2'b10, 2'b11);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_g",         32'({g_a, g_b, g_c, g_r}), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // Directed single operations: a=b=c=1 recombined, then c=0.
    drive_op(2'b10, 2'b01, 2'b10);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check_val("single_one", 32'(out_d[0] ^ out_d[1]), 32'd1);
    drive_op(2'b10, 2'b01, 2'b11);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check_val("single_zero", 32'(out_d[0] ^ out_d[1]), 32'd0);

    // Seed 1, one idle step, then issue: g_r = low bits of lfsr_adv(1) = 2'b11.
    seed_valid = 1'b1; seed = 32'h0000_0001;
    tick();
    seed_valid = 1'b0;
    tick();
    drive_op(2'b11, 2'b01, 2'b10);
    tick();
    check_val("seed1_g_r", 32'(g_r), 32'd3);
    in_valid = 1'b0;
    repeat (6) tick();
    drive_op(2'b01, 2'b01, 2'b01);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();

    // Zero seed loads the default; seed together with in_valid refuses the operand.
    seed_valid = 1'b1; seed = 32'h0;
    drive_op(2'b01, 2'b10, 2'b01);
    tick();
    check_val("seed_vs_op_busy", 32'(busy), 32'd0);
    seed_valid = 1'b0;
    tick();
    // Seed during HOLD is ignored.
    in_valid = 1'b0;
    tick();
    seed_valid = 1'b1; seed = 32'h1234_5678;
    tick();
    seed_valid = 1'b0;
    repeat (6) tick();
    drive_op(2'b10, 2'b10, 2'b01);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();

    // Backpressure: result held, new operands refused until after the handshake.
    drive_op(2'b01, 2'b01, 2'b10);
    out_ready = 1'b0;
    tick();
    drive_op(2'b11, 2'b10, 2'b01);
    repeat (14) tick();
    check_val("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check_val("bp_reaccept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    repeat (6) tick();

    // Back-to-back random operations at full rate.
    track_rate = 1'b1; last_res = -1; start = n_res;
    for (int i = 0; i < 100 * (LAT + 3) + 20 && (n_res - start) < 100; i++) begin
      drive_op(2'($urandom), 2'($urandom), 2'($urandom));
      tick();
    end
    check_val("btb_count", 32'(n_res - start), 32'd100);
    track_rate = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();

    // Fully random traffic including seeds and backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom);
      in_a       = 2'($urandom); in_b = 2'($urandom); in_c = 2'($urandom);
      seed_valid = ($urandom_range(0, 7) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      out_ready  = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
